fft_digit_rev_reorder: RTL and testbench

//  Output reorder buffer after the last radix-4 butterfly stage of the SDF FFT pipeline.
//  The last stage emits bins in radix-4 digit-reversed order; this block restores natural order.

---
 rtl/fft_digit_rev_reorder.sv | 104 ++++++++++
 tb/tb_fft_digit_rev_reorder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fft_digit_rev_reorder.sv
// Ping-pong reorder buffer: radix-4 digit-reversed FFT output back to natural bin order.
// Optional REORDER_STATUS_EN adds the frame_err sop-mismatch status pulse.
module fft_digit_rev_reorder #(
   parameter int unsigned WORDLENGTH_IO = 16,
   parameter int unsigned LOG4_N        = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       sop_in,
   input  logic [2*WORDLENGTH_IO-1:0] data_in,
   output logic [2*WORDLENGTH_IO-1:0] data_out,
   output logic                       out_valid,
   output logic                       out_sop
`ifdef REORDER_STATUS_EN
   ,
   output logic                       frame_err
`endif
);

   localparam int unsigned SW    = 2 * WORDLENGTH_IO;
   localparam int unsigned IDX_W = 2 * LOG4_N;
   localparam int unsigned N     = 1 << IDX_W;

   // Reverse the order of the 2-bit radix-4 digits; bits inside a digit keep their order.
   function automatic logic [IDX_W-1:0] digitrev(input logic [IDX_W-1:0] k);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int unsigned d = 0; d < LOG4_N; d++) begin
         r[2*d +: 2] = k[2*(LOG4_N-1-d) +: 2];
      end
      return r;
   endfunction

   logic [SW-1:0]    mem [2][N];
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             wr_bank;
   logic             rd_bank;
   logic             rd_active;

   logic [IDX_W-1:0] wr_addr_c;
   logic             last_c;

   // sop_in restarts the current bank at address 0, discarding any partial frame.
   always_comb begin
      wr_addr_c = wr_idx;
      if (sop_in) wr_addr_c = '0;
      last_c = (wr_addr_c == IDX_W'(N - 1));
   end

   // Bank storage carries no reset.
   always_ff @(posedge clk) begin
      if (enable && !rst) mem[wr_bank][wr_addr_c] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out  <= '0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         wr_idx    <= '0;
         rd_idx    <= '0;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         rd_active <= 1'b0;
      end else if (enable) begin
         wr_idx <= wr_addr_c + IDX_W'(1);
         if (rd_active) begin
            data_out  <= mem[rd_bank][digitrev(rd_idx)];
            out_valid <= 1'b1;
            out_sop   <= (rd_idx == '0);
            rd_idx    <= rd_idx + IDX_W'(1);
            if (rd_idx == IDX_W'(N - 1)) rd_active <= 1'b0;
         end else begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
         end
         // A completed bank hands over even on the last read cycle, so streaming has no bubble.
         if (last_c) begin
            wr_bank   <= ~wr_bank;
            rd_bank   <= wr_bank;
            rd_active <= 1'b1;
            rd_idx    <= '0;
         end
      end
   end

`ifdef REORDER_STATUS_EN
   logic wrapped;

   // Flags an early sop, or a missing sop on the first sample after a completed frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrapped   <= 1'b0;
         frame_err <= 1'b0;
      end else if (enable) begin
         wrapped   <= last_c;
         frame_err <= (sop_in && (wr_idx != '0)) || (wrapped && !sop_in);
      end
   end
`endif

endmodule

// File: tb/tb_fft_digit_rev_reorder.sv
// Directed self-checking bench for fft_digit_rev_reorder (N=64); honours REORDER_STATUS_EN.
module tb_fft_digit_rev_reorder;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        sop_in;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        out_valid;
   logic        out_sop;
`ifdef REORDER_STATUS_EN
   logic        frame_err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic        ev;
   logic        es;
   logic [31:0] ed;

   fft_digit_rev_reorder #(.WORDLENGTH_IO(16), .LOG4_N(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .sop_in    (sop_in),
      .data_in   (data_in),
      .data_out  (data_out),
      .out_valid (out_valid),
      .out_sop   (out_sop)
`ifdef REORDER_STATUS_EN
      ,
      .frame_err (frame_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1);
   end

   // Independent digit reversal for N=64: three 2-bit digits swapped end for end.
   function automatic logic [5:0] dr(input logic [5:0] k);
      return {k[1:0], k[3:2], k[5:4]};
   endfunction

   function automatic logic [31:0] exp_word(input int k);
      return {16'(k), ~16'(k)};
   endfunction

   // Sample at arrival position p carries bin dr(p).
   function automatic logic [31:0] frame_word(input int p);
      return exp_word(int'(dr(6'(p))));
   endfunction

   task automatic tick(input logic r, input logic e, input logic s, input logic [31:0] d);
      rst = r; enable = e; sop_in = s; data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b1, 1'b0, 32'h0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 32'hffff_ffff);
      n_cmp++; if (data_out !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want %h", data_out, 32'h0); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_cmp++; if (out_sop !== 1'b0) begin n_err++; $display("FAIL reset_sop got %b want 0", out_sop); end
`ifdef REORDER_STATUS_EN
      n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
`endif
   endtask

   task automatic test_order();
      do_reset();
      for (int c = 0; c < 128; c++) begin
         tick(1'b0, 1'b1, (c == 0), (c < 64) ? frame_word(c) : 32'h0);
         ev = (c >= 64);
         es = (c == 64);
         ed = (c >= 64) ? exp_word(c - 64) : 32'h0;
         n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL order_valid c=%0d got %b want %b", c, out_valid, ev); end
         n_cmp++; if (out_sop !== es) begin n_err++; $display("FAIL order_sop c=%0d got %b want %b", c, out_sop, es); end
         n_cmp++; if (data_out !== ed) begin n_err++; $display("FAIL order_data c=%0d got %h want %h", c, data_out, ed); end
      end
   endtask

   task automatic test_back_to_back();
      int f;
      int k;
      do_reset();
      for (int c = 0; c < 320; c++) begin
         tick(1'b0, 1'b1, (c < 256) && (c % 64 == 0),
              (c < 256) ? {16'((c / 64) * 64 + int'(dr(6'(c % 64)))), 16'(c / 64)} : 32'h0);
         f  = (c - 64) / 64;
         k  = (c - 64) % 64;
         ev = (c >= 64);
         es = (c >= 64) && (k == 0);
         ed = (c >= 64) ? {16'(f * 64 + k), 16'(f)} : 32'h0;
         n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL b2b_valid c=%0d got %b want %b", c, out_valid, ev); end
         n_cmp++; if (out_sop !== es) begin n_err++; $display("FAIL b2b_sop c=%0d got %b want %b", c, out_sop, es); end
         n_cmp++; if (data_out !== ed) begin n_err++; $display("FAIL b2b_data c=%0d got %h want %h", c, data_out, ed); end
      end
   endtask

   task automatic test_enable_gating();
      int  c;
      int  cl;
      int  guard;
      logic e;
      c = 0;
      guard = 0;
      do_reset();
      while (c < 128 && guard < 2000) begin
         e = 1'($urandom_range(0, 1));
         tick(1'b0, e, (c == 0), (c < 64) ? frame_word(c) : 32'h0);
         if (e) c++;
         cl = c - 1;
         ev = (cl >= 64);
         es = (cl == 64);
         ed = (cl >= 64) ? exp_word(cl - 64) : 32'h0;
         n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL gate_valid en_cnt=%0d en=%b got %b want %b", c, e, out_valid, ev); end
         n_cmp++; if (out_sop !== es) begin n_err++; $display("FAIL gate_sop en_cnt=%0d en=%b got %b want %b", c, e, out_sop, es); end
         n_cmp++; if (data_out !== ed) begin n_err++; $display("FAIL gate_data en_cnt=%0d en=%b got %h want %h", c, e, data_out, ed); end
         guard++;
      end
      n_cmp++; if (c < 128) begin n_err++; $display("FAIL gate_budget got %0d enables want 128", c); end
   endtask

   task automatic test_resync();
      do_reset();
      for (int c = 0; c < 148; c++) begin
         if (c < 20)      tick(1'b0, 1'b1, (c == 0), {16'h8000 | 16'(c), 16'hffff});
         else if (c < 84) tick(1'b0, 1'b1, (c == 20), frame_word(c - 20));
         else             tick(1'b0, 1'b1, 1'b0, 32'h0);
         ev = (c >= 84);
         es = (c == 84);
         ed = (c >= 84) ? exp_word(c - 84) : 32'h0;
         n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL resync_valid c=%0d got %b want %b", c, out_valid, ev); end
         n_cmp++; if (out_sop !== es) begin n_err++; $display("FAIL resync_sop c=%0d got %b want %b", c, out_sop, es); end
         n_cmp++; if (data_out !== ed) begin n_err++; $display("FAIL resync_data c=%0d got %h want %h", c, data_out, ed); end
`ifdef REORDER_STATUS_EN
         if (c >= 19 && c <= 21) begin
            n_cmp++;
            if (frame_err !== (c == 20)) begin
               n_err++; $display("FAIL resync_frame_err c=%0d got %b want %b", c, frame_err, (c == 20));
            end
         end
`endif
      end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      for (int c = 0; c < 94; c++) tick(1'b0, 1'b1, (c == 0), (c < 64) ? frame_word(c) : 32'h0);
      n_cmp++; if (data_out !== exp_word(29)) begin n_err++; $display("FAIL midrd_pre_data got %h want %h", data_out, exp_word(29)); end
      // Reset with enable low: reset must still take effect.
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrd_rst_valid got %b want 0", out_valid); end
      n_cmp++; if (out_sop !== 1'b0) begin n_err++; $display("FAIL midrd_rst_sop got %b want 0", out_sop); end
      n_cmp++; if (data_out !== 32'h0) begin n_err++; $display("FAIL midrd_rst_data got %h want 0", data_out); end
      for (int c = 0; c < 128; c++) begin
         tick(1'b0, 1'b1, (c == 0), (c < 64) ? {16'(dr(6'(c))), 16'h5a5a} : 32'h0);
         ev = (c >= 64);
         es = (c == 64);
         ed = (c >= 64) ? {16'(c - 64), 16'h5a5a} : 32'h0;
         n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL midrd_valid c=%0d got %b want %b", c, out_valid, ev); end
         n_cmp++; if (out_sop !== es) begin n_err++; $display("FAIL midrd_sop c=%0d got %b want %b", c, out_sop, es); end
         n_cmp++; if (data_out !== ed) begin n_err++; $display("FAIL midrd_data c=%0d got %h want %h", c, data_out, ed); end
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; sop_in = 1'b0; data_in = 32'h0;
      test_reset();
      test_order();
      test_back_to_back();
      test_enable_gating();
      test_resync();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
